// File: rtl/hls_run_pkg.sv
// Shared types for the HLS run controller: FSM states, result status codes and the result record.
package hls_run_pkg;

  localparam int unsigned REC_CNT_W  = 32;
  localparam int unsigned REC_RUNS_W = 16;
  localparam int unsigned REC_SUM_W  = 48;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    ARM,
    START,
    RUN,
    REPORT
  } state_t;

  localparam logic [1:0] ST_NOCHECK = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [1:0]            status;
    logic [REC_CNT_W-1:0]  cycles;
    logic [REC_RUNS_W-1:0] index;
  } res_rec_t;

endpackage

// File: rtl/hls_run_controller_if.sv
// Per-run result channel: one record per run, held stable until accepted.
interface hls_run_controller_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned RUNS_W = 16
) ();

  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_status;
  logic [CNT_W-1:0]  res_cycles;
  logic [RUNS_W-1:0] res_index;

  modport master (
    output res_valid,
    output res_status,
    output res_cycles,
    output res_index,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_status,
    input  res_cycles,
    input  res_index,
    output res_ready
  );

endinterface

// File: rtl/hls_run_stats.sv
// Batch statistics: saturating cycle sum, min/max over completed runs, saturating failure count.
module hls_run_stats
  import hls_run_pkg::*;
#(
  parameter int unsigned CNT_W  = REC_CNT_W,
  parameter int unsigned RUNS_W = REC_RUNS_W,
  parameter int unsigned SUM_W  = REC_SUM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              cap,
  input  logic [1:0]        status,
  input  logic [CNT_W-1:0]  cycles,
  output logic [SUM_W-1:0]  sum_cycles,
  output logic [CNT_W-1:0]  min_cycles,
  output logic [CNT_W-1:0]  max_cycles,
  output logic [RUNS_W-1:0] fail_count
);

  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  min_q;
  logic [CNT_W-1:0]  max_q;
  logic [RUNS_W-1:0] fail_q;
  logic [SUM_W:0]    sum_ext_c;

  // One extra bit exposes the carry used for saturation.
  assign sum_ext_c = {1'b0, sum_q} + (SUM_W + 1)'(cycles);

  // Accumulate on each captured record; a new batch restarts from the empty state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
      fail_q <= '0;
    end else if (clr) begin
      sum_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
      fail_q <= '0;
    end else if (cap) begin
      sum_q <= sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];
      if (status != ST_TIMEOUT) begin
        if (cycles < min_q) min_q <= cycles;
        if (cycles > max_q) max_q <= cycles;
      end
      if ((status == ST_FAIL || status == ST_TIMEOUT) && fail_q != '1) begin
        fail_q <= fail_q + RUNS_W'(1);
      end
    end
  end

  assign sum_cycles = sum_q;
  assign min_cycles = min_q;
  assign max_cycles = max_q;
  assign fail_count = fail_q;

endmodule

// File: rtl/hls_run_controller.sv
// Sequences an HLS accelerator through a batch of runs: reset, start, done/timeout, report.
module hls_run_controller
  import hls_run_pkg::*;
#(
  parameter int unsigned CNT_W      = REC_CNT_W,
  parameter int unsigned RUNS_W     = REC_RUNS_W,
  parameter int unsigned SUM_W      = REC_SUM_W,
  parameter int unsigned TIMEOUT    = 200000000,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_go,
  input  logic [RUNS_W-1:0]    cfg_runs,
  input  logic                 cfg_check_en,
  output logic                 busy,
  output logic                 acc_reset,
  output logic                 acc_start_port,
  input  logic                 acc_done_port,
  input  logic                 acc_check_ok,
  hls_run_controller_if.master res,
  output logic [SUM_W-1:0]     sum_cycles,
  output logic [CNT_W-1:0]     min_cycles,
  output logic [CNT_W-1:0]     max_cycles,
  output logic [RUNS_W-1:0]    fail_count,
  output logic                 batch_done
);

  localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [RST_CNT_W-1:0]  rst_cnt_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [RUNS_W-1:0]     runs_q;
  logic [RUNS_W-1:0]     idx_q;
  logic                  check_q;
  logic                  abort_q;
  res_rec_t              rec_q;
  logic                  busy_q, acc_reset_q, acc_start_q, res_valid_q, batch_done_q;

  logic                  clr_c, cap_c, hs_c, last_c;
  logic [1:0]            cap_status_c;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus capture/clear/handshake strobes.
  always_comb begin
    state_d      = state_q;
    clr_c        = 1'b0;
    cap_c        = 1'b0;
    hs_c         = 1'b0;
    cap_status_c = ST_NOCHECK;
    last_c       = (idx_q == runs_q - RUNS_W'(1));
    case (state_q)
      IDLE: begin
        if (cfg_go) begin
          state_d = RST;
          clr_c   = 1'b1;
        end
      end
      RST: begin
        if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) state_d = ARM;
      end
      ARM: state_d = START;
      START, RUN: begin
        // A done arriving on the limit cycle still counts as a completed run.
        if (acc_done_port) begin
          cap_c        = 1'b1;
          cap_status_c = !check_q ? ST_NOCHECK : (acc_check_ok ? ST_PASS : ST_FAIL);
          state_d      = REPORT;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          cap_c        = 1'b1;
          cap_status_c = ST_TIMEOUT;
          state_d      = REPORT;
        end else begin
          state_d = RUN;
        end
      end
      REPORT: begin
        if (res.res_ready) begin
          hs_c    = 1'b1;
          state_d = (abort_q || last_c) ? IDLE : RST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Batch configuration, counters, result record and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_cnt_q    <= '0;
      cnt_q        <= '0;
      runs_q       <= '0;
      idx_q        <= '0;
      check_q      <= 1'b0;
      abort_q      <= 1'b0;
      rec_q        <= '0;
      busy_q       <= 1'b0;
      acc_reset_q  <= 1'b0;
      acc_start_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      if (clr_c) begin
        runs_q  <= (cfg_runs == '0) ? RUNS_W'(1) : cfg_runs;
        check_q <= cfg_check_en;
        idx_q   <= '0;
        abort_q <= 1'b0;
      end
      rst_cnt_q <= (state_q == RST && state_d == RST) ? rst_cnt_q + RST_CNT_W'(1) : '0;
      if (state_d == START)    cnt_q <= CNT_W'(1);
      else if (state_d == RUN) cnt_q <= cnt_q + CNT_W'(1);
      if (cap_c) begin
        rec_q.status <= cap_status_c;
        rec_q.cycles <= REC_CNT_W'(cnt_q);
        rec_q.index  <= REC_RUNS_W'(idx_q);
        abort_q      <= (cap_status_c == ST_TIMEOUT);
      end
      if (hs_c && state_d == RST) idx_q <= idx_q + RUNS_W'(1);
      busy_q       <= (state_d != IDLE);
      acc_reset_q  <= (state_d == ARM) || (state_d == START) ||
                      (state_d == RUN) || (state_d == REPORT);
      acc_start_q  <= (state_d == START);
      res_valid_q  <= (state_d == REPORT);
      batch_done_q <= hs_c && (state_d == IDLE);
    end
  end

  hls_run_stats #(
    .CNT_W  (CNT_W),
    .RUNS_W (RUNS_W),
    .SUM_W  (SUM_W)
  ) u_stats (
    .clock      (clock),
    .reset      (reset),
    .clr        (clr_c),
    .cap        (cap_c),
    .status     (cap_status_c),
    .cycles     (cnt_q),
    .sum_cycles (sum_cycles),
    .min_cycles (min_cycles),
    .max_cycles (max_cycles),
    .fail_count (fail_count)
  );

  assign busy           = busy_q;
  assign acc_reset      = acc_reset_q;
  assign acc_start_port = acc_start_q;
  assign batch_done     = batch_done_q;
  assign res.res_valid  = res_valid_q;
  assign res.res_status = rec_q.status;
  assign res.res_cycles = CNT_W'(rec_q.cycles);
  assign res.res_index  = RUNS_W'(rec_q.index);

endmodule

// File: tb/tb_hls_run_controller.sv
// Directed bench for hls_run_controller with a short timeout so abort paths are reachable.
module tb_hls_run_controller;
  import hls_run_pkg::*;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned RUNS_W = 16;
  localparam int unsigned SUM_W  = 48;
  localparam int unsigned TO     = 16;
  localparam int          NEVER  = 255;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_go = 1'b0;
  logic [RUNS_W-1:0] cfg_runs = '0;
  logic              cfg_check_en = 1'b0;
  logic              busy, acc_reset, acc_start_port, batch_done;
  logic              acc_done_port = 1'b0;
  logic              acc_check_ok = 1'b0;
  logic [SUM_W-1:0]  sum_cycles;
  logic [CNT_W-1:0]  min_cycles, max_cycles;
  logic [RUNS_W-1:0] fail_count;

  int tests = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hls_run_controller_if #(.CNT_W(CNT_W), .RUNS_W(RUNS_W)) res_if ();

  hls_run_controller #(
    .CNT_W(CNT_W), .RUNS_W(RUNS_W), .SUM_W(SUM_W), .TIMEOUT(TO), .RST_CYCLES(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_go         (cfg_go),
    .cfg_runs       (cfg_runs),
    .cfg_check_en   (cfg_check_en),
    .busy           (busy),
    .acc_reset      (acc_reset),
    .acc_start_port (acc_start_port),
    .acc_done_port  (acc_done_port),
    .acc_check_ok   (acc_check_ok),
    .res            (res_if.master),
    .sum_cycles     (sum_cycles),
    .min_cycles     (min_cycles),
    .max_cycles     (max_cycles),
    .fail_count     (fail_count),
    .batch_done     (batch_done)
  );

  typedef struct {
    logic        chk_en;
    int          lat;
    logic        ok;
    logic [1:0]  st;
    int unsigned cyc;
    logic [31:0] mn;
    logic [31:0] mx;
    int unsigned fails;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_batch(input logic [RUNS_W-1:0] runs, input logic en);
    cfg_runs     = runs;
    cfg_check_en = en;
    cfg_go       = 1'b1;
    step();
    cfg_go       = 1'b0;
  endtask

  // Wait for the start pulse, then raise done 'lat' cycles after it (lat 0 = in the start cycle).
  task automatic do_run(input int lat, input logic ok, input string tag);
    int lowcnt = 0;
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (acc_start_port) begin
        seen = 1'b1;
        break;
      end
      if (busy && !acc_reset) lowcnt++;
      step();
    end
    chk({tag, " start seen"}, 64'(seen), 64'(1));
    chk({tag, " acc_reset low cycles"}, 64'(lowcnt), 64'(2));
    if (lat != NEVER) begin
      for (int i = 0; i < lat; i++) begin
        step();
        if (i == 0) chk({tag, " start width"}, 64'(acc_start_port), 64'(0));
      end
      acc_done_port = 1'b1;
      acc_check_ok  = ok;
      step();
      acc_done_port = 1'b0;
      acc_check_ok  = 1'b0;
    end
  endtask

  task automatic get_record(input logic [1:0] st, input int unsigned cyc,
                            input int unsigned idx, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (res_if.res_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, " res_valid"}, 64'(seen), 64'(1));
    chk({tag, " status"}, 64'(res_if.res_status), 64'(st));
    chk({tag, " cycles"}, 64'(res_if.res_cycles), 64'(cyc));
    chk({tag, " index"}, 64'(res_if.res_index), 64'(idx));
  endtask

  task automatic handshake(input bit last, input string tag);
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
    chk({tag, " batch_done"}, 64'(batch_done), 64'(last));
    chk({tag, " busy after hs"}, 64'(busy), 64'(!last));
    if (last) begin
      step();
      chk({tag, " batch_done pulse"}, 64'(batch_done), 64'(0));
    end
  endtask

  task automatic chk_stats(input logic [47:0] s, input logic [31:0] mn, input logic [31:0] mx,
                           input int unsigned f, input string tag);
    chk({tag, " sum"}, 64'(sum_cycles), 64'(s));
    chk({tag, " min"}, 64'(min_cycles), 64'(mn));
    chk({tag, " max"}, 64'(max_cycles), 64'(mx));
    chk({tag, " fail_count"}, 64'(fail_count), 64'(f));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " acc_reset"}, 64'(acc_reset), 64'(0));
    chk({tag, " acc_start"}, 64'(acc_start_port), 64'(0));
    chk({tag, " res_valid"}, 64'(res_if.res_valid), 64'(0));
    chk({tag, " res_status"}, 64'(res_if.res_status), 64'(0));
    chk({tag, " res_cycles"}, 64'(res_if.res_cycles), 64'(0));
    chk({tag, " res_index"}, 64'(res_if.res_index), 64'(0));
    chk({tag, " batch_done"}, 64'(batch_done), 64'(0));
    chk_stats(48'd0, 32'hFFFF_FFFF, 32'd0, 0, tag);
  endtask

  initial begin
    int bad;
    res_if.res_ready = 1'b0;

    // chk_en, lat, ok, status, cycles, min, max, fails
    vecs[0] = '{1'b0, 9,     1'b0, ST_NOCHECK, 10, 32'd10,       32'd0 + 10, 0};
    vecs[1] = '{1'b1, 0,     1'b1, ST_PASS,    1,  32'd1,        32'd1,      0};
    vecs[2] = '{1'b1, 2,     1'b0, ST_FAIL,    3,  32'd3,        32'd3,      1};
    vecs[3] = '{1'b1, 15,    1'b1, ST_PASS,    16, 32'd16,       32'd16,     0};
    vecs[4] = '{1'b0, 14,    1'b1, ST_NOCHECK, 15, 32'd15,       32'd15,     0};
    vecs[5] = '{1'b1, NEVER, 1'b1, ST_TIMEOUT, 16, 32'hFFFF_FFFF, 32'd0,     1};
    vecs[6] = '{1'b0, NEVER, 1'b0, ST_TIMEOUT, 16, 32'hFFFF_FFFF, 32'd0,     1};

    step();
    step();
    chk_reset_values("reset");
    reset = 1'b1;
    step();
    step();
    chk("idle acc_reset", 64'(acc_reset), 64'(0));

    // Single-run batches from the vector table.
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_batch(1, vecs[i].chk_en);
      do_run(vecs[i].lat, vecs[i].ok, tag);
      get_record(vecs[i].st, vecs[i].cyc, 0, tag);
      chk_stats(48'(vecs[i].cyc), vecs[i].mn, vecs[i].mx, vecs[i].fails, tag);
      handshake(1'b1, tag);
      chk({tag, " idle acc_reset"}, 64'(acc_reset), 64'(0));
    end

    // Three back-to-back checked runs.
    start_batch(3, 1'b1);
    do_run(5, 1'b1, "b3r0");
    get_record(ST_PASS, 6, 0, "b3r0");
    handshake(1'b0, "b3r0");
    do_run(7, 1'b0, "b3r1");
    get_record(ST_FAIL, 8, 1, "b3r1");
    handshake(1'b0, "b3r1");
    do_run(6, 1'b1, "b3r2");
    get_record(ST_PASS, 7, 2, "b3r2");
    chk_stats(48'd21, 32'd6, 32'd8, 1, "b3");
    handshake(1'b1, "b3r2");

    // Timeout aborts a 4-run batch after its first run.
    start_batch(4, 1'b1);
    do_run(NEVER, 1'b0, "abort");
    get_record(ST_TIMEOUT, TO, 0, "abort");
    handshake(1'b1, "abort");
    chk("abort acc_reset", 64'(acc_reset), 64'(0));
    chk_stats(48'd16, 32'hFFFF_FFFF, 32'd0, 1, "abort");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || acc_start_port) bad++;
    end
    chk("abort stays idle", 64'(bad), 64'(0));

    // Done in the start cycle, then 20 cycles of back-pressure.
    start_batch(2, 1'b1);
    do_run(0, 1'b1, "stall");
    get_record(ST_PASS, 1, 0, "stall");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!res_if.res_valid || acc_start_port || !busy || res_if.res_status != ST_PASS ||
          res_if.res_cycles != 1 || res_if.res_index != 0) bad++;
    end
    chk("stall record stable", 64'(bad), 64'(0));
    handshake(1'b0, "stall");
    do_run(3, 1'b1, "stall2");
    get_record(ST_PASS, 4, 1, "stall2");
    chk_stats(48'd5, 32'd1, 32'd4, 0, "stall2");
    handshake(1'b1, "stall2");

    // Asynchronous reset in the middle of the second run.
    start_batch(3, 1'b0);
    do_run(2, 1'b0, "mid0");
    get_record(ST_NOCHECK, 3, 0, "mid0");
    handshake(1'b0, "mid0");
    do_run(NEVER, 1'b0, "mid1");
    step();
    step();
    step();
    chk("mid1 running", 64'(busy && acc_reset), 64'(1));
    reset = 1'b0;
    #1;
    chk_reset_values("async");
    step();
    reset = 1'b1;
    step();
    start_batch(1, 1'b1);
    do_run(3, 1'b1, "after_rst");
    get_record(ST_PASS, 4, 0, "after_rst");
    chk_stats(48'd4, 32'd4, 32'd4, 0, "after_rst");
    handshake(1'b1, "after_rst");

    // cfg_runs=0 runs once; a go pulse while busy is ignored.
    start_batch(0, 1'b0);
    do_run(4, 1'b0, "zero");
    get_record(ST_NOCHECK, 5, 0, "zero");
    cfg_runs = 5;
    cfg_go   = 1'b1;
    step();
    cfg_go   = 1'b0;
    chk("busy go record held", 64'(res_if.res_valid), 64'(1));
    handshake(1'b1, "zero");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || acc_start_port) bad++;
    end
    chk("zero single run", 64'(bad), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hls_run_controller.md
Name: hls_run_controller

Overview:
- Synthesizable successor to the simulation-only HLS driver FSM.
- Sequences an HLS-generated accelerator through programmable back-to-back runs: reset hold, start pulse, done wait, cycle counting, timeout abort, pass/fail capture.
- Emits one result record per run over a valid/ready port and keeps aggregate statistics.
- Sits between the on-board test sequencer and one accelerator instance (e.g. mergesort top).

Parameters:
- CNT_W, 32, width of per-run cycle counter and timeout.
- RUNS_W, 16, width of run count/index.
- SUM_W, 48, width of total-cycle accumulator.
- TIMEOUT, 200000000, cycle limit per run; the run aborts when the count reaches it.
- RST_CYCLES, 2, cycles acc_reset is held low before each start (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- cfg_go  in  1  pulse: begin a batch (ignored while busy)
- cfg_runs  in  RUNS_W  runs in batch, sampled on cfg_go; 0 treated as 1
- cfg_check_en  in  1  sampled on cfg_go; enables pass/fail capture
- busy  out  1  batch in progress
- acc_reset  out  1  accelerator reset, active-low
- acc_start_port  out  1  one-cycle start pulse to accelerator
- acc_done_port  in  1  accelerator done
- acc_check_ok  in  1  external comparator verdict, sampled with acc_done_port
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_status  out  2  0 NOCHECK, 1 PASS, 2 FAIL, 3 TIMEOUT
- res_cycles  out  CNT_W  cycles of this run
- res_index  out  RUNS_W  run number, 0-based
- sum_cycles  out  SUM_W  total cycles of completed runs, saturating
- min_cycles  out  CNT_W  minimum over non-timeout runs
- max_cycles  out  CNT_W  maximum over non-timeout runs
- fail_count  out  RUNS_W  FAIL + TIMEOUT runs, saturating
- batch_done  out  1  one-cycle pulse when batch finishes or aborts

Behaviour:
- Reset values: busy 0, acc_reset 0, acc_start_port 0, res_valid 0, all data outputs 0, min_cycles all-ones, batch_done 0. FSM is IDLE.
- FSM states and transitions:
  - IDLE: acc_reset held 0. On cfg_go: latch config, clear statistics, go to RST.
  - RST: acc_reset 0 for RST_CYCLES cycles, then go to ARM.
  - ARM: acc_reset 1 for exactly one cycle, then go to START.
  - START: acc_start_port=1 for one cycle; cycle counter loads 1.
    - If acc_done_port is high in this cycle, finish the run with count 1.
    - Otherwise go to RUN.
  - RUN: counter increments each cycle; acc_start_port=0.
    - On acc_done_port=1: capture the count (inclusive of the done cycle) and the status, then go to REPORT.
    - If the count reaches TIMEOUT without done: status TIMEOUT, res_cycles=TIMEOUT, set an abort flag, go to REPORT.
- Cycle count: start cycle = 1. Done on the cycle after start gives 2.
- Status rule: check disabled gives NOCHECK; otherwise acc_check_ok=1 gives PASS and 0 gives FAIL.
- REPORT: res_valid=1; record stays stable until res_ready. Statistics update in the same cycle the record is captured, not on handshake. On the handshake:
  - abort set, or last run: go to IDLE, pulse batch_done, drop busy.
  - otherwise: increment the index and go to RST, so every run starts from a fresh accelerator reset.
- busy=1 in every state except IDLE.
- acc_done_port is ignored outside START and RUN.
- Statistics: sum saturates at all-ones. TIMEOUT runs add TIMEOUT to sum but do not update min/max. fail_count saturates.
- cfg_go while busy: ignored, no effect.
- Asynchronous reset mid-run: immediate return to reset values; acc_reset driven 0 asynchronously.
- res_ready held high: one record per run, no lost records. Back-pressure stalls the batch indefinitely with no timeout.

Decomposition:
- Package hls_run_pkg holds: the state enum (IDLE, RST, ARM, START, RUN, REPORT); the status encoding constants ST_NOCHECK/ST_PASS/ST_FAIL/ST_TIMEOUT; the result record struct {status, cycles, index}.
- One natural sub-module, hls_run_stats: accumulates sum, min, max and fail_count from a capture strobe plus the record, with saturation.

Test Plan:
- cfg_runs=1, check off, done 9 cycles after start -> one record {NOCHECK, cycles=10, index=0}; batch_done pulses once; acc_reset low 2 cycles before start.
- cfg_runs=3, check on, latencies 5/7/6, ok=1,0,1 -> statuses PASS/FAIL/PASS, cycles 6/8/7; sum=21, min=6, max=8, fail_count=1.
- TIMEOUT=16 override, done never arrives, cfg_runs=4 -> single record {TIMEOUT, 16, 0}; batch aborts; acc_reset returns low; min stays all-ones.
- Done in the START cycle -> cycles=1; res_ready held low 20 cycles -> record stable, no new start until the handshake.
- Reset asserted mid-RUN of run 2 -> all outputs at reset values immediately; a subsequent cfg_go restarts at index 0 with cleared statistics.
- cfg_go pulsed while busy and cfg_runs=0 -> the busy pulse is ignored; runs=0 executes exactly one run.
